conv_row_accum: RTL and testbench

CONV_ROW_ACCUM -- requirements
Module: conv_row_accum

---
 rtl/conv_row_accum_pkg.sv | 17 +
 rtl/conv_row_accum_if.sv | 15 +
 rtl/conv_row_accum_requant_sat.sv | 33 +++
 rtl/conv_row_accum.sv | 68 ++++++
 tb/tb_conv_row_accum.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_row_accum_pkg.sv
// Shared widths and types for the convolution row accumulator.
package conv_row_accum_pkg;
  localparam int DATA_BITS     = 16;
  localparam int INTERNAL_BITS = 32;
  localparam int KROWS_DEF     = 3;
  localparam int ACC_BITS      = 34;
  localparam int SHIFT_BITS    = 5;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 sat;
  } rq_t;

  function automatic logic signed [ACC_BITS-1:0] sext_acc(input logic signed [INTERNAL_BITS-1:0] v);
    return ACC_BITS'(v);
  endfunction
endpackage

// File: rtl/conv_row_accum_if.sv
// Psum input stream and pixel output stream of the row accumulator.
interface conv_row_accum_if;
  import conv_row_accum_pkg::*;
  logic                     psum_valid;
  logic                     psum_ready;
  logic [INTERNAL_BITS-1:0] psum_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_BITS-1:0]     out_data;

  modport master (output psum_valid, psum_in, out_ready,
                  input  psum_ready, out_valid, out_data);
  modport slave  (input  psum_valid, psum_in, out_ready,
                  output psum_ready, out_valid, out_data);
endinterface

// File: rtl/conv_row_accum_requant_sat.sv
// Combinational ReLU, round-half-up right shift and saturation to DATA_BITS.
module requant_sat
  import conv_row_accum_pkg::*;
(
  input  logic signed [ACC_BITS-1:0]   sum,
  input  logic        [SHIFT_BITS-1:0] shift_amt,
  input  logic                         relu_en,
  output rq_t                          res
);
  // One guard bit so the rounding add cannot wrap near the accumulator limit
  localparam int W = ACC_BITS + 1;
  localparam logic signed [W-1:0] MAXV = W'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

  logic signed [W-1:0] relu_v, rnd, shifted;

  always_comb begin
    relu_v = W'(sum);
    if (relu_en && sum[ACC_BITS-1]) relu_v = '0;
    rnd = '0;
    if (shift_amt != '0) rnd = W'(1) << (shift_amt - SHIFT_BITS'(1));
    shifted  = (relu_v + rnd) >>> shift_amt;
    res.sat  = 1'b0;
    res.data = shifted[DATA_BITS-1:0];
    if (shifted > MAXV) begin
      res.data = MAXV[DATA_BITS-1:0];
      res.sat  = 1'b1;
    end else if (shifted < MINV) begin
      res.data = MINV[DATA_BITS-1:0];
      res.sat  = 1'b1;
    end
  end
endmodule

// File: rtl/conv_row_accum.sv
// Sums KROWS PE row results plus bias into one requantized output pixel.
module conv_row_accum
  import conv_row_accum_pkg::*;
#(
  parameter int KROWS = KROWS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  conv_row_accum_if.slave          bus,
  input  logic                     bias_load,
  input  logic [INTERNAL_BITS-1:0] bias_in,
  input  logic [SHIFT_BITS-1:0]    shift_amt,
  input  logic                     relu_en,
  input  logic                     flush,
  output logic [1:0]               row_cnt,
  output logic                     sat_flag
);
  localparam logic [1:0] LAST = 2'(KROWS - 1);

  logic signed [ACC_BITS-1:0]      acc, base, sum;
  logic signed [INTERNAL_BITS-1:0] bias_r;
  logic                            last_row, accept, out_valid_r;
  logic [DATA_BITS-1:0]            out_data_r;
  rq_t                             rq;

  assign last_row       = (row_cnt == LAST);
  // Only the completing beat needs a free output slot
  assign bus.psum_ready = !(last_row && out_valid_r && !bus.out_ready);
  assign accept         = bus.psum_valid && bus.psum_ready && !flush;
  assign base           = (row_cnt == 2'd0) ? sext_acc(bias_r) : acc;
  assign sum            = base + sext_acc(bus.psum_in);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;

  requant_sat u_rq (
    .sum       (sum),
    .shift_amt (shift_amt),
    .relu_en   (relu_en),
    .res       (rq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      bias_r      <= '0;
      row_cnt     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      sat_flag    <= 1'b0;
    end else begin
      if (flush) begin
        row_cnt <= '0;
        acc     <= '0;
      end else if (accept) begin
        row_cnt <= last_row ? 2'd0 : row_cnt + 2'd1;
        acc     <= sum;
      end
      if (bias_load && row_cnt == 2'd0 && !accept) bias_r <= bias_in;
      if (accept && last_row) begin
        out_data_r  <= rq.data;
        out_valid_r <= 1'b1;
        sat_flag    <= sat_flag | rq.sat;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_row_accum.sv
// Directed and random checks of conv_row_accum against an arithmetic pixel model.
module tb_conv_row_accum;
  import conv_row_accum_pkg::*;

  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        bias_load, relu_en, flush, sat_flag;
  logic [31:0] bias_in;
  logic [4:0]  shift_amt;
  logic [1:0]  row_cnt;

  always #5 clk = ~clk;

  conv_row_accum_if bus ();

  conv_row_accum #(.KROWS(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .bias_load (bias_load),
    .bias_in   (bias_in),
    .shift_amt (shift_amt),
    .relu_en   (relu_en),
    .flush     (flush),
    .row_cnt   (row_cnt),
    .sat_flag  (sat_flag)
  );

  int n_chk = 0, n_fail = 0;

  // Model state: pixel in progress as a running integer sum
  longint      m_bias, m_acc;
  int          m_row;
  bit          m_sat;
  logic [15:0] m_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input longint s_in, input int sh, input bit relu, output bit sat);
    longint s;
    s = s_in;
    if (relu && s < 0) s = 0;
    if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
    s = s >>> sh;
    sat = 1'b0;
    if (s > 32767) begin s = 32767; sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input bit bl = 1'b0, input int bv = 0);
    int     t;
    bit     done, s;
    longint total;
    bus.psum_valid = 1'b1;
    bus.psum_in    = p;
    bias_load      = bl;
    bias_in        = bv;
    #1;
    t = 0;
    while (!bus.psum_ready && t < 50) begin tick(); t++; end
    chk("ready_wait", 64'(bus.psum_ready), 64'(1));
    total = ((m_row == 0) ? m_bias : m_acc) + longint'(p);
    done  = (m_row == K - 1);
    if (done) begin
      m_out = ref_pix(total, int'(shift_amt), relu_en, s);
      m_sat = m_sat | s;
    end else m_acc = total;
    m_row = done ? 0 : m_row + 1;
    tick();
    bus.psum_valid = 1'b0;
    bias_load      = 1'b0;
    chk("row_cnt", 64'(row_cnt), 64'(m_row));
    if (done) begin
      chk("out_valid", 64'(bus.out_valid), 64'(1));
      chk("out_data", 64'(bus.out_data), 64'(m_out));
      chk("sat_flag", 64'(sat_flag), 64'(m_sat));
    end
  endtask

  task automatic load_bias(input int v);
    bias_load = 1'b1;
    bias_in   = v;
    if (m_row == 0) m_bias = longint'(v);
    tick();
    bias_load = 1'b0;
  endtask

  task automatic pixel(input int a, input int b, input int c);
    beat(a); beat(b); beat(c);
  endtask

  initial begin
    logic [15:0] p1;
    rst = 1'b0;
    bus.psum_valid = 1'b0; bus.psum_in = '0; bus.out_ready = 1'b1;
    bias_load = 1'b0; bias_in = '0; shift_amt = '0; relu_en = 1'b0; flush = 1'b0;
    m_bias = 0; m_acc = 0; m_row = 0; m_sat = 1'b0; m_out = '0;
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_sat", 64'(sat_flag), 64'(0));
    chk("rst_row", 64'(row_cnt), 64'(0));
    @(negedge clk); rst = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.psum_ready), 64'(1));

    // Basic pixel with bias and rounding
    load_bias(40); shift_amt = 5'd4; relu_en = 1'b0;
    pixel(100, 200, 300);
    chk("px40", 64'(bus.out_data), 64'(16'd40));
    tick();
    chk("valid_drop", 64'(bus.out_valid), 64'(0));

    // Negative sums with and without ReLU
    load_bias(0); relu_en = 1'b1;
    pixel(-100, -200, -300);
    chk("relu_zero", 64'(bus.out_data), 64'(16'd0));
    relu_en = 1'b0;
    pixel(-100, -200, -300);
    chk("neg37", 64'(bus.out_data), 64'(16'hFFDB));

    // Positive saturation sets the sticky flag
    shift_amt = 5'd0;
    pixel(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("sat_max", 64'(bus.out_data), 64'(16'h7FFF));
    pixel(1, 2, 3);
    chk("sat_sticky", 64'(sat_flag), 64'(1));
    tick();

    // Output stall: third beat of the next pixel waits for out_ready
    bus.out_ready = 1'b0;
    pixel(11, 22, 33);
    p1 = m_out;
    beat(44); beat(55);
    bus.psum_valid = 1'b1; bus.psum_in = 66;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 64'(bus.psum_ready), 64'(0));
      chk("stall_hold", 64'(bus.out_data), 64'(p1));
      chk("stall_valid", 64'(bus.out_valid), 64'(1));
      tick();
    end
    chk("stall_row", 64'(row_cnt), 64'(2));
    bus.out_ready = 1'b1;
    beat(66);
    chk("px2_after_stall", 64'(bus.out_data), 64'(16'd165));
    tick();

    // Flush drops the partial pixel and the beat presented with it
    beat(7); beat(9);
    flush = 1'b1; bus.psum_valid = 1'b1; bus.psum_in = 1000;
    tick();
    flush = 1'b0; bus.psum_valid = 1'b0;
    m_row = 0;
    chk("flush_row", 64'(row_cnt), 64'(0));
    load_bias(5);
    pixel(1, 1, 1);
    chk("flush_px8", 64'(bus.out_data), 64'(16'd8));

    // Reset in the middle of a pixel
    beat(50);
    @(negedge clk); rst = 1'b0;
    #2;
    chk("mid_rst_row", 64'(row_cnt), 64'(0));
    chk("mid_rst_sat", 64'(sat_flag), 64'(0));
    m_bias = 0; m_acc = 0; m_row = 0; m_sat = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    pixel(10, 20, 30);
    chk("rst_px60", 64'(bus.out_data), 64'(16'd60));

    // Random pixels, controls re-randomized every beat
    for (int px = 0; px < 40; px++) begin
      if ($urandom_range(0, 2) == 0) load_bias(int'($urandom_range(0, 20000)) - 10000);
      for (int r = 0; r < K; r++) begin
        int p;
        shift_amt = 5'($urandom_range(0, 31));
        relu_en   = 1'($urandom_range(0, 1));
        p = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
        if ($urandom_range(0, 5) == 0 && r != 0) load_bias(int'($urandom));
        beat(p, ($urandom_range(0, 4) == 0), int'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
